// File: rtl/iiitb_vend_pkg.sv
// Shared vending definitions: change codes, coin values and dispenser states.
// Imported by both the vend FSM and the change dispenser.
package iiitb_vend_pkg;

    localparam logic [2:0] CODE_NONE   = 3'b000;
    localparam logic [2:0] NICKEL      = 3'b001;
    localparam logic [2:0] DIME        = 3'b010;
    localparam logic [2:0] NICKEL_DIME = 3'b011;
    localparam logic [2:0] DIME_DIME   = 3'b100;
    localparam logic [2:0] QUARTER     = 3'b101;

    // Coin values in nickel units; a change code's value equals its amount.
    localparam logic [2:0] NICKEL_VAL  = 3'd1;
    localparam logic [2:0] DIME_VAL    = 3'd2;

    typedef enum logic [2:0] {
        DISP_IDLE,
        DISP_EJECT,
        DISP_WAIT_ACK,
        DISP_DONE,
        DISP_FAULT
    } disp_state_e;

    function automatic logic code_is_legal(input logic [2:0] code);
        return code <= DIME_DIME;
    endfunction

endpackage

// File: rtl/iiitb_coin_tube.sv
// One hopper tube's coin inventory: saturating refill, single-coin decrement.
// Refill and decrement are never requested together by the dispenser.
module iiitb_coin_tube #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_amt,
    input  logic             dec_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        // NOTE: defaults first so every path assigns count_d and no latch is inferred.
        sum     = {1'b0, count_q} + {1'b0, load_amt};
        count_d = count_q;
        if (load_en) begin
            count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (dec_en && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state is written with <= only, so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/iiitb_change_dispenser.sv
// Pays out a change code as nickels/dimes through a two-tube hopper, one coin
// at a time with an eject/ack handshake and a sticky timeout fault.
module iiitb_change_dispenser #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [2:0]       change_code,
    output logic             change_ready,
    output logic             eject_nickel,
    output logic             eject_dime,
    input  logic             hopper_done,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_nickels,
    input  logic [CNT_W-1:0] load_dimes,
    input  logic             clear_fault,
    output logic             done,
    output logic             short,
    output logic             fault,
    output logic             busy,
    output logic [CNT_W-1:0] nickel_count,
    output logic [CNT_W-1:0] dime_count
);

    import iiitb_vend_pkg::*;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    disp_state_e      state_q;
    logic [2:0]       remaining_q;
    logic [TMR_W-1:0] timer_q;
    logic             short_q;
    logic             coin_dime_q;

    logic       payable;
    logic [2:0] half_amt, dimes_use, nickels_need;
    logic       pick_dime, ack;
    logic [2:0] coin_val;

    // Feasibility on pre-edge counts: spend as many dimes as possible, then nickels.
    always_comb begin
        half_amt     = change_code >> 1;
        dimes_use    = (dime_count >= CNT_W'(half_amt)) ? half_amt : dime_count[2:0];
        nickels_need = change_code - (dimes_use << 1);
        payable      = code_is_legal(change_code) && (CNT_W'(nickels_need) <= nickel_count);
    end

    assign pick_dime = (remaining_q >= DIME_VAL) && (dime_count != '0);
    assign ack       = (state_q == DISP_WAIT_ACK) && hopper_done;
    assign coin_val  = coin_dime_q ? DIME_VAL : NICKEL_VAL;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= DISP_IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
            short_q     <= 1'b0;
            coin_dime_q <= 1'b0;
        end else begin
            case (state_q)
                DISP_IDLE: if (change_valid) begin
                    short_q <= 1'b0;
                    if (change_code == CODE_NONE) begin
                        state_q <= DISP_DONE;
                    end else if (!payable) begin
                        short_q <= 1'b1;
                        state_q <= DISP_DONE;
                    end else begin
                        remaining_q <= change_code;
                        state_q     <= DISP_EJECT;
                    end
                end
                DISP_EJECT: begin
                    coin_dime_q <= pick_dime;
                    timer_q     <= '0;
                    state_q     <= DISP_WAIT_ACK;
                end
                DISP_WAIT_ACK: begin
                    // An ack landing on the timeout cycle still counts the coin.
                    if (hopper_done) begin
                        remaining_q <= remaining_q - coin_val;
                        state_q     <= (remaining_q == coin_val) ? DISP_DONE : DISP_EJECT;
                    end else if (timer_q == TMR_LAST) begin
                        state_q <= DISP_FAULT;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                DISP_DONE: state_q <= DISP_IDLE;
                DISP_FAULT: if (clear_fault) begin
                    state_q     <= DISP_IDLE;
                    remaining_q <= '0;
                end
                default: state_q <= DISP_IDLE;
            endcase
        end
    end

    iiitb_coin_tube #(.CNT_W(CNT_W)) u_nickel_tube (
        .clock    (clock),
        .reset    (reset),
        .load_en  (load_en && state_q == DISP_IDLE),
        .load_amt (load_nickels),
        .dec_en   (ack && !coin_dime_q),
        .count    (nickel_count)
    );

    iiitb_coin_tube #(.CNT_W(CNT_W)) u_dime_tube (
        .clock    (clock),
        .reset    (reset),
        .load_en  (load_en && state_q == DISP_IDLE),
        .load_amt (load_dimes),
        .dec_en   (ack && coin_dime_q),
        .count    (dime_count)
    );

    assign change_ready = (state_q == DISP_IDLE);
    assign busy         = (state_q != DISP_IDLE);
    assign done         = (state_q == DISP_DONE);
    assign short        = (state_q == DISP_DONE) && short_q;
    assign fault        = (state_q == DISP_FAULT);
    assign eject_dime   = (state_q == DISP_EJECT) && pick_dime;
    assign eject_nickel = (state_q == DISP_EJECT) && !pick_dime;

endmodule

// File: tb/tb_iiitb_change_dispenser.sv
// Randomized bench: a transaction-level payout model predicts every output on
// every cycle; a few literal checks pin the model to hand-computed results.
module tb_iiitb_change_dispenser;

    import iiitb_vend_pkg::*;

    localparam int CNT_W   = 8;
    localparam int MAXC    = 255;
    localparam int TIMEOUT = 1000;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             change_valid = 1'b0;
    logic [2:0]       change_code = 3'b000;
    logic             change_ready, eject_nickel, eject_dime;
    logic             hopper_done = 1'b0;
    logic             load_en = 1'b0;
    logic [CNT_W-1:0] load_nickels = '0;
    logic [CNT_W-1:0] load_dimes = '0;
    logic             clear_fault = 1'b0;
    logic             done, short, fault, busy;
    logic [CNT_W-1:0] nickel_count, dime_count;

    always #5 clock = ~clock;

    iiitb_change_dispenser #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT), .TMR_W(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .change_valid (change_valid),
        .change_code  (change_code),
        .change_ready (change_ready),
        .eject_nickel (eject_nickel),
        .eject_dime   (eject_dime),
        .hopper_done  (hopper_done),
        .load_en      (load_en),
        .load_nickels (load_nickels),
        .load_dimes   (load_dimes),
        .clear_fault  (clear_fault),
        .done         (done),
        .short        (short),
        .fault        (fault),
        .busy         (busy),
        .nickel_count (nickel_count),
        .dime_count   (dime_count)
    );

    typedef struct {
        bit ready, ej_n, ej_d, done, shrt, fault, busy;
        int ncnt, dcnt;
    } exp_t;

    typedef enum {K_IDLE, K_EJ_N, K_EJ_D, K_WAIT, K_DONE, K_SHORT, K_FAULT} kind_e;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_n = 0;
    int   m_d = 0;
    int   cnt_ej_n = 0;
    int   cnt_ej_d = 0;
    bit   check_en = 1'b0;
    exp_t exp_next, exp_cur;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t mk(input kind_e k);
        exp_t e;
        e.ready = (k == K_IDLE);
        e.busy  = (k != K_IDLE);
        e.ej_n  = (k == K_EJ_N);
        e.ej_d  = (k == K_EJ_D);
        e.done  = (k == K_DONE) || (k == K_SHORT);
        e.shrt  = (k == K_SHORT);
        e.fault = (k == K_FAULT);
        e.ncnt  = m_n;
        e.dcnt  = m_d;
        return e;
    endfunction

    function automatic int sat(input int a, input int b);
        return (a + b > MAXC) ? MAXC : a + b;
    endfunction

    always @(posedge clock) exp_cur <= exp_next;

    always @(negedge clock) begin
        if (eject_nickel) cnt_ej_n++;
        if (eject_dime)   cnt_ej_d++;
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("change_ready", int'(change_ready), int'(exp_cur.ready));
            check("eject_nickel", int'(eject_nickel), int'(exp_cur.ej_n));
            check("eject_dime",   int'(eject_dime),   int'(exp_cur.ej_d));
            check("done",         int'(done),         int'(exp_cur.done));
            check("short",        int'(short),        int'(exp_cur.shrt));
            check("fault",        int'(fault),        int'(exp_cur.fault));
            check("busy",         int'(busy),         int'(exp_cur.busy));
            check("nickel_count", int'(nickel_count), exp_cur.ncnt);
            check("dime_count",   int'(dime_count),   exp_cur.dcnt);
        end
    end

    // Model counts must already reflect this edge before step() is called.
    task automatic step(input kind_e k);
        exp_next = mk(k);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        change_valid = 1'b0;
        hopper_done  = 1'b0;
        load_en      = 1'b0;
        clear_fault  = 1'b0;
    endtask

    task automatic load(input int ln, input int ld);
        load_en      = 1'b1;
        load_nickels = CNT_W'(ln);
        load_dimes   = CNT_W'(ld);
        m_n = sat(m_n, ln);
        m_d = sat(m_d, ld);
        step(K_IDLE);
        load_en = 1'b0;
    endtask

    task automatic request(input logic [2:0] code, input bit with_load, input int ln, input int ld,
                           input int min_delay, input int max_delay);
        int amt, d, n, rem, delay;
        bit short_req, pay, pick_d;
        amt = int'(code);
        short_req = 1'b0;
        pay = 1'b0;
        if (amt > 4) begin
            short_req = 1'b1;
        end else if (amt != 0) begin
            d = (amt / 2 < m_d) ? amt / 2 : m_d;
            n = amt - 2 * d;
            if (n > m_n) short_req = 1'b1;
            else         pay = 1'b1;
        end
        change_valid = 1'b1;
        change_code  = code;
        if (with_load) begin
            load_en      = 1'b1;
            load_nickels = CNT_W'(ln);
            load_dimes   = CNT_W'(ld);
            m_n = sat(m_n, ln);
            m_d = sat(m_d, ld);
        end
        if (!pay) begin
            step(short_req ? K_SHORT : K_DONE);
            idle_inputs();
            step(K_IDLE);
            return;
        end
        rem = amt;
        pick_d = (rem >= 2) && (m_d > 0);
        step(pick_d ? K_EJ_D : K_EJ_N);
        idle_inputs();
        while (rem > 0) begin
            step(K_WAIT);
            delay = int'($urandom_range(max_delay, min_delay));
            repeat (delay) begin
                load_en      = ($urandom % 4 == 0);
                load_nickels = CNT_W'($urandom_range(9, 1));
                load_dimes   = CNT_W'($urandom_range(9, 1));
                step(K_WAIT);
            end
            load_en     = 1'b0;
            hopper_done = 1'b1;
            if (pick_d) begin m_d--; rem -= 2; end
            else        begin m_n--; rem -= 1; end
            if (rem == 0) begin
                step(K_DONE);
            end else begin
                pick_d = (rem >= 2) && (m_d > 0);
                step(pick_d ? K_EJ_D : K_EJ_N);
            end
            hopper_done = 1'b0;
        end
        step(K_IDLE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] code;

        #12;
        check("reset_busy",  int'(busy),         0);
        check("reset_fault", int'(fault),        0);
        check("reset_done",  int'(done),         0);
        check("reset_ncnt",  int'(nickel_count), 0);
        check("reset_dcnt",  int'(dime_count),   0);
        @(posedge clock);
        #1 reset = 1'b1;
        step(K_IDLE);
        check_en = 1'b1;
        check("ready_after_reset", int'(change_ready), 1);

        // 3 nickels + 2 dimes, DIME_DIME acked after 2 cycles -> two dimes out.
        load(3, 2);
        cnt_ej_n = 0; cnt_ej_d = 0;
        request(DIME_DIME, 1'b0, 0, 0, 2, 2);
        check("dd_dime_pulses",   cnt_ej_d, 2);
        check("dd_nickel_pulses", cnt_ej_n, 0);
        check("dd_dime_count",    int'(dime_count),   0);
        check("dd_nickel_count",  int'(nickel_count), 3);

        // 4 nickels, no dimes -> DIME_DIME paid as four nickels.
        load(1, 0);
        cnt_ej_n = 0; cnt_ej_d = 0;
        request(DIME_DIME, 1'b0, 0, 0, 0, 3);
        check("nn_nickel_pulses", cnt_ej_n, 4);
        check("nn_dime_pulses",   cnt_ej_d, 0);
        check("nn_nickel_count",  int'(nickel_count), 0);

        // 1 nickel, no dimes -> DIME is short, nothing ejected.
        load(1, 0);
        cnt_ej_n = 0; cnt_ej_d = 0;
        request(DIME, 1'b0, 0, 0, 0, 0);
        request(3'b111, 1'b0, 0, 0, 0, 0);
        request(CODE_NONE, 1'b0, 0, 0, 0, 0);
        check("short_no_ejects",   cnt_ej_n + cnt_ej_d, 0);
        check("short_nickel_kept", int'(nickel_count), 1);

        // Randomized traffic with concurrent loads and stray hopper_done.
        for (int i = 0; i < 80; i++) begin
            if ($urandom % 3 == 0) load(int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
            if ($urandom % 3 == 0) begin
                hopper_done = 1'b1;
                step(K_IDLE);
                hopper_done = 1'b0;
            end
            code = ($urandom % 4 == 0) ? 3'($urandom_range(7, 0)) : 3'($urandom_range(4, 1));
            request(code, ($urandom % 4 == 0), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 0, 4);
        end

        // Hopper never acks -> fault after TIMEOUT cycles in WAIT_ACK.
        load(2, 0);
        change_valid = 1'b1;
        change_code  = NICKEL;
        step(K_EJ_N);
        idle_inputs();
        step(K_WAIT);
        repeat (TIMEOUT - 1) step(K_WAIT);
        step(K_FAULT);
        change_valid = 1'b1;
        change_code  = NICKEL;
        hopper_done  = 1'b1;
        load_en      = 1'b1;
        load_nickels = 8'd9;
        step(K_FAULT);
        step(K_FAULT);
        idle_inputs();
        check("fault_flag",  int'(fault),        1);
        check("fault_ready", int'(change_ready), 0);
        check("fault_ncnt",  int'(nickel_count), m_n);
        clear_fault = 1'b1;
        step(K_IDLE);
        clear_fault = 1'b0;
        step(K_IDLE);
        check("cleared_ready", int'(change_ready), 1);

        // Ack on the very last timeout cycle wins over the fault.
        request(NICKEL, 1'b0, 0, 0, TIMEOUT - 1, TIMEOUT - 1);
        check("late_ack_no_fault", int'(fault), 0);
        request(NICKEL_DIME, 1'b1, 2, 1, 0, 2);

        // Reset mid-WAIT_ACK.
        load(5, 5);
        change_valid = 1'b1;
        change_code  = NICKEL;
        step(K_EJ_N);
        idle_inputs();
        step(K_WAIT);
        check_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_busy",  int'(busy),         0);
        check("midrst_eject", int'(eject_nickel | eject_dime), 0);
        check("midrst_fault", int'(fault),        0);
        check("midrst_ncnt",  int'(nickel_count), 0);
        check("midrst_dcnt",  int'(dime_count),   0);
        m_n = 0;
        m_d = 0;
        exp_next = mk(K_IDLE);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 check_en = 1'b1;
        step(K_IDLE);

        // Saturating refill.
        load(250, 200);
        load(10, 200);
        check("sat_nickels", int'(nickel_count), 255);
        check("sat_dimes",   int'(dime_count),   255);
        request(DIME_DIME, 1'b0, 0, 0, 0, 1);
        check("after_sat_dimes", int'(dime_count), 253);
        step(K_IDLE);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iiitb_change_dispenser.md
Name: iiitb_change_dispenser

Overview:
- Back end of the vending path: consumes the 3-bit change code issued by the vend FSM and pays it out as physical coins through a two-tube hopper (nickel tube, dime tube).
- Tracks per-tube coin inventory, checks that a request can be paid before ejecting anything, and sequences one coin at a time with an eject/ack handshake.
- Faults to a sticky state if the hopper fails to acknowledge within a timeout.

Parameters:
- CNT_W, 8, width of each tube inventory counter (saturating).
- TIMEOUT_CYCLES, 1000, cycles allowed in WAIT_ACK for hopper_done before fault.
- TMR_W, 10, timeout counter width; must satisfy 2^TMR_W >= TIMEOUT_CYCLES.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- change_valid  in  1  change request present.
- change_code  in  3  000 none, 001 NICKEL, 010 DIME, 011 NICKEL_DIME, 100 DIME_DIME, 101-111 illegal.
- change_ready  out  1  high only in IDLE; request accepted on change_valid && change_ready.
- eject_nickel  out  1  one-cycle command to eject one nickel.
- eject_dime  out  1  one-cycle command to eject one dime.
- hopper_done  in  1  one-cycle pulse: the commanded coin was sensed leaving the tube.
- load_en  in  1  refill strobe.
- load_nickels  in  CNT_W  nickels added on load_en.
- load_dimes  in  CNT_W  dimes added on load_en.
- clear_fault  in  1  exits FAULT.
- done  out  1  one-cycle pulse: request finished.
- short  out  1  qualifies done: request not paid (insufficient inventory or illegal code).
- fault  out  1  high while in FAULT.
- busy  out  1  high in any state other than IDLE.
- nickel_count  out  CNT_W  current nickel inventory.
- dime_count  out  CNT_W  current dime inventory.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; all pulses, fault and busy are 0.
  - change_ready 1 after reset is released.
  - Counts 0, remaining amount 0, timer 0.
- Amount is held in nickel units: code value 0-4 maps directly to amount 0-4 (3-bit register).
- States: IDLE, EJECT, WAIT_ACK, DONE, FAULT. All outputs are registered or Moore-decoded from state.
- IDLE, on accept at edge T:
  - Code 000: go to DONE; done=1, short=0 in cycle T+1; no coins ejected.
  - Code 101-111: go to DONE with short=1; inventory unchanged.
  - Legal code, feasibility check on pre-edge counts: d = min(amount/2, dime_count), n = amount - 2d.
    - If n > nickel_count: DONE with short=1; nothing ejected.
    - Otherwise latch the amount and go to EJECT.
- EJECT (one cycle):
  - If remaining >= 2 and dime_count > 0, assert eject_dime; otherwise assert eject_nickel.
  - Clear the timer, go to WAIT_ACK.
- WAIT_ACK:
  - On hopper_done, decrement the ejected coin's count by 1 and remaining by its value (dime 2, nickel 1).
  - If remaining becomes 0, go to DONE; otherwise go to EJECT.
  - If the timer reaches TIMEOUT_CYCLES-1 with no hopper_done, go to FAULT; that coin is not decremented.
  - hopper_done on the same cycle as the timeout wins: the coin is counted and there is no fault.
- DONE (one cycle): done=1, short as decided at accept, then IDLE.
- FAULT:
  - fault=1, change_ready=0; eject outputs are held at 0.
  - clear_fault moves to IDLE and zeroes remaining.
  - reset also exits FAULT.
- hopper_done is ignored outside WAIT_ACK.
- Single-coin latency: accept at T, eject at T+1, hopper_done at earliest T+2, done at T+3.
- Refill:
  - load_en is honoured only in IDLE and ignored otherwise.
  - Each count becomes min(count + load, 2^CNT_W - 1).
  - load_en together with an accept in the same cycle: feasibility uses pre-load counts, and both the load and the accept take effect.
- change_valid/change_code outside IDLE are ignored; the upstream FSM must hold change_valid until ready.
- No other simultaneous events are possible, since decrements occur only in WAIT_ACK.

Decomposition:
- Shared package iiitb_vend_pkg holds:
  - Coin codes NICKEL=001, DIME=010, NICKEL_DIME=011, DIME_DIME=100, QUARTER=101.
  - The dispenser state encoding.
  - Coin values in nickel units.
  - This package is also imported by the vend FSM.
- One natural sub-module, iiitb_coin_tube: a saturating load/decrement inventory counter, instantiated twice.

Test Plan:
- Load 3 nickels, 2 dimes; request DIME_DIME, ack each eject after 2 cycles -> two eject_dime pulses; done=1, short=0; dime_count=0, nickel_count=3.
- Counts nickels=4, dimes=0; request DIME_DIME -> four eject_nickel pulses; done without short; nickel_count=0.
- Counts nickels=1, dimes=0; request DIME -> done=1, short=1 at T+1; no eject pulses; counts unchanged.
- Request NICKEL with no hopper_done -> fault=1 after TIMEOUT_CYCLES in WAIT_ACK; change_ready=0; nickel_count unchanged. clear_fault -> IDLE, change_ready=1.
- Request code 111, and separately code 000 -> done at T+1 with short=1 and short=0 respectively; no ejects.
- nickel_count=250 (CNT_W=8), load_nickels=10 -> count saturates at 255. Assert reset low mid-WAIT_ACK -> immediate IDLE, outputs 0, counts 0.
